// File: rtl/spi_time_pkg.sv
// Shared constants, types and helpers for the SPI time-transfer slave.
package spi_time_pkg;

  localparam int unsigned BITS_PER_BYTE      = 8;
  localparam int unsigned BYTES_PER_FRAME    = 3;
  localparam int unsigned DEFAULT_MAX_HOURS  = 24;
  localparam int unsigned DEFAULT_MAX_MINSEC = 60;

  // Position of each field inside the received frame.
  localparam int unsigned HOURS_IDX   = 0;
  localparam int unsigned MINUTES_IDX = 1;
  localparam int unsigned SECONDS_IDX = 2;

  typedef logic [BITS_PER_BYTE-1:0] byte_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck,
    StDone
  } spi_state_e;

  // Unsigned range check of one received field against its exclusive limit.
  function automatic logic below_limit(input byte_t value, input int unsigned limit);
    return 32'(value) < limit;
  endfunction

endpackage

// File: rtl/spi_time_slave_if.sv
// SPI pin bundle between the time-link master and the slave receiver.
interface spi_time_slave_if;

  logic scl;
  logic mosi;
  logic ss;
  logic miso;

  modport master (
    output scl,
    output mosi,
    output ss,
    input  miso
  );

  modport slave (
    input  scl,
    input  mosi,
    input  ss,
    output miso
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin plus registered rise/fall strobes.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift chain and edge compare against the previous synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // State registers; reset to the pin's idle level so no edge fires on release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_time_slave.sv
// SPI slave that receives an hours/minutes/seconds frame, range-checks it and
// commits all three fields atomically. Received bytes are echoed on miso one
// byte late for link checking.
module spi_time_slave
  import spi_time_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_HOURS   = DEFAULT_MAX_HOURS,
  parameter int unsigned MAX_MINSEC  = DEFAULT_MAX_MINSEC
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_time_slave_if.slave      spi,
  output logic [7:0]           hours,
  output logic [7:0]           minutes,
  output logic [7:0]           seconds,
  output logic                 time_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam logic [2:0] LastBit  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0] LastByte = 2'(BYTES_PER_FRAME - 1);

  logic scl_rise, scl_fall, scl_level;
  logic ss_rise, ss_fall, ss_level;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_scl (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (spi.scl),
    .level_o (scl_level),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_mosi (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (spi.mosi),
    .level_o (mosi_level),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  // ss idles high, so its synchronizer resets high.
  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_ss (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (spi.ss),
    .level_o (ss_level),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  assign unused_edges = ^{mosi_rise, mosi_fall, scl_level};

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  byte_t      shift_q, shift_d;
  byte_t      echo_q, echo_d;
  logic       miso_q, miso_d;
  byte_t      stage_q [BYTES_PER_FRAME];
  byte_t      stage_d [BYTES_PER_FRAME];
  byte_t      hours_q, hours_d;
  byte_t      minutes_q, minutes_d;
  byte_t      seconds_q, seconds_d;
  logic       time_valid_q, time_valid_d;
  logic       frame_error_q, frame_error_d;
  byte_t      rx_byte;
  logic       frame_ok;

  // Byte completed by the current scl fall (MSB first).
  assign rx_byte  = {shift_q[BITS_PER_BYTE-2:0], mosi_level};
  assign frame_ok = below_limit(stage_q[HOURS_IDX], MAX_HOURS) &
                    below_limit(stage_q[MINUTES_IDX], MAX_MINSEC) &
                    below_limit(stage_q[SECONDS_IDX], MAX_MINSEC);

  // Next-state, shift/echo datapath and commit logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    echo_d        = echo_q;
    miso_d        = miso_q;
    stage_d       = stage_q;
    hours_d       = hours_q;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    time_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        echo_d     = '0;
        miso_d     = 1'b0;
        if (ss_fall) begin
          state_d = StShift;
        end
      end

      StShift: begin
        if (ss_rise) begin
          // Master gave up mid-frame: drop everything received so far.
          frame_error_d = 1'b1;
          stage_d       = '{default: '0};
          state_d       = StIdle;
        end else begin
          if (scl_fall) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LastBit) begin
              stage_d[byte_cnt_q] = rx_byte;
              // Byte n goes out on miso while byte n+1 is shifted in.
              echo_d              = rx_byte;
              byte_cnt_d          = byte_cnt_q + 2'd1;
              if (byte_cnt_q == LastByte) begin
                state_d = StCheck;
              end
            end
          end
          if (scl_rise) begin
            miso_d = echo_q[BITS_PER_BYTE-1];
            echo_d = {echo_q[BITS_PER_BYTE-2:0], 1'b0};
          end
        end
      end

      StCheck: begin
        miso_d = 1'b0;
        if (frame_ok) begin
          hours_d      = stage_q[HOURS_IDX];
          minutes_d    = stage_q[MINUTES_IDX];
          seconds_d    = stage_q[SECONDS_IDX];
          time_valid_d = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
        state_d = StDone;
      end

      StDone: begin
        // Trailing scl activity is ignored; leave once ss is seen high.
        miso_d = 1'b0;
        if (ss_level) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      shift_q       <= '0;
      echo_q        <= '0;
      miso_q        <= 1'b0;
      stage_q       <= '{default: '0};
      hours_q       <= '0;
      minutes_q     <= '0;
      seconds_q     <= '0;
      time_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      echo_q        <= echo_d;
      miso_q        <= miso_d;
      stage_q       <= stage_d;
      hours_q       <= hours_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      time_valid_q  <= time_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign spi.miso    = miso_q;
  assign hours       = hours_q;
  assign minutes     = minutes_q;
  assign seconds     = seconds_q;
  assign time_valid  = time_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q == StShift);

endmodule

// File: tb/tb_spi_time_slave.sv
// Self-checking bench for spi_time_slave: table of frames plus corner sequences,
// with a scoreboard of expected commit/error pulses.
module tb_spi_time_slave;
  import spi_time_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hours, minutes, seconds;
  logic       time_valid, frame_error, busy;

  spi_time_slave_if spi ();

  spi_time_slave #(
    .SYNC_STAGES (2),
    .MAX_HOURS   (24),
    .MAX_MINSEC  (60)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .time_valid  (time_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } exp_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         exp_err;
  } vec_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] mh = 8'h00, mm = 8'h00, ms = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every pulse and tracks the committed outputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (time_valid || frame_error) begin
        check("pulse_exclusive", {31'd0, time_valid & frame_error}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, time_valid, frame_error}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind", {31'd0, frame_error}, {31'd0, e.is_err});
          if (!e.is_err) begin
            mh = e.h;
            mm = e.m;
            ms = e.s;
          end
        end
      end
      check("hours", {24'd0, hours}, {24'd0, mh});
      check("minutes", {24'd0, minutes}, {24'd0, mm});
      check("seconds", {24'd0, seconds}, {24'd0, ms});
    end
  end

  // Drives one frame of nbits bits, then extra scl cycles; optionally resets mid-frame.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input bit exp_err, input int nbits, input int extra,
                            input int gap, input bit mid_reset);
    logic [23:0] data;
    logic [23:0] echo_exp;
    logic [23:0] echo_got;
    exp_t        e;
    data     = {b0, b1, b2};
    echo_exp = {8'h00, b0, b1};
    echo_got = '0;
    if (!mid_reset) begin
      e.is_err = exp_err || (nbits < 24);
      e.h = b0;
      e.m = b1;
      e.s = b2;
      sb.push_back(e);
    end
    spi.ss = 1'b0;
    tick(6);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      spi.scl = 1'b1;
      tick(2);
      spi.mosi = data[23-i];
      tick(3);
      echo_got[23-i] = spi.miso;
      spi.scl = 1'b0;
      tick(5);
    end
    for (int j = 0; j < extra; j++) begin
      spi.scl = 1'b1;
      tick(5);
      check("miso_after_frame", {31'd0, spi.miso}, 32'd0);
      spi.scl = 1'b0;
      tick(5);
    end
    if (mid_reset) begin
      reset = 1'b1;
      mh = 8'h00;
      mm = 8'h00;
      ms = 8'h00;
      #1;
      check("rst_hours", {24'd0, hours}, 32'd0);
      check("rst_minutes", {24'd0, minutes}, 32'd0);
      check("rst_seconds", {24'd0, seconds}, 32'd0);
      check("rst_flags", {28'd0, time_valid, frame_error, busy, spi.miso}, 32'd0);
      spi.ss  = 1'b1;
      spi.scl = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(4);
    end else begin
      for (int k = 0; k < nbits / BITS_PER_BYTE; k++) begin
        check("miso_echo", {24'd0, echo_got[23-8*k -: 8]}, {24'd0, echo_exp[23-8*k -: 8]});
      end
      tick(2);
      spi.ss = 1'b1;
      tick(gap);
      for (int w = 0; w < 40 && sb.size() != 0; w++) tick(1);
      check("pulse_seen", sb.size(), 32'd0);
      sb.delete();
      check("busy_after_frame", {31'd0, busy}, 32'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h18, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{8'h17, 8'h3B, 8'h3B, 1'b0};
    vecs[2] = '{8'h17, 8'h3C, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h3B, 8'h3C, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{8'h0A, 8'h14, 8'h1E, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h05, 8'h06, 8'h07, 1'b0};

    reset    = 1'b1;
    spi.ss   = 1'b1;
    spi.scl  = 1'b0;
    spi.mosi = 1'b0;
    tick(3);
    check("reset_outputs", {hours, minutes, seconds}, 32'd0);
    check("reset_flags", {28'd0, time_valid, frame_error, busy, spi.miso}, 32'd0);
    reset = 1'b0;
    tick(5);
    check("idle_flags", {28'd0, time_valid, frame_error, busy, spi.miso}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].exp_err, 24, 0, 8, 1'b0);
    end
    check("table_final", {hours, minutes, seconds}, 32'h050607);

    // Abort after 12 bits, then a clean frame.
    send_frame(8'h05, 8'h1E, 8'h00, 1'b1, 12, 0, 8, 1'b0);
    check("abort_hold", {hours, minutes, seconds}, 32'h050607);
    send_frame(8'h01, 8'h02, 8'h03, 1'b0, 24, 0, 8, 1'b0);
    check("after_abort", {hours, minutes, seconds}, 32'h010203);

    // Reset in the middle of byte 2, then a clean frame.
    send_frame(8'h17, 8'h3B, 8'h3B, 1'b0, 12, 0, 8, 1'b1);
    send_frame(8'h0C, 8'h22, 8'h38, 1'b0, 24, 0, 8, 1'b0);
    check("after_reset", {hours, minutes, seconds}, 32'h0C2238);

    // Back-to-back frames with trailing scl activity.
    send_frame(8'h01, 8'h01, 8'h01, 1'b0, 24, 30, 4, 1'b0);
    send_frame(8'h02, 8'h2A, 8'h3A, 1'b0, 24, 30, 8, 1'b0);
    check("back_to_back", {hours, minutes, seconds}, 32'h022A3A);

    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_time_slave.md
# spi_time_slave

SPI slave receiver for the time-transfer link: it deserializes the 3-byte frame (hours, minutes, seconds, MSB first) that the SPI master shifts out on `scl`/`mosi` under `ss`. It range-checks the frame and commits it atomically to a set of time registers for the receiving side of the design. The block runs entirely in the system clock domain and oversamples the asynchronous SPI pins. `miso` echoes received bytes back to the master for link checking.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `scl`, `mosi`, `ss` (≥2).
- `MAX_HOURS`, 24: hours accepted if value < MAX_HOURS.
- `MAX_MINSEC`, 60: minutes/seconds accepted if value < MAX_MINSEC.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scl`  in  1  SPI clock from master; asynchronous.
- `mosi`  in  1  serial data from master; changes after rising `scl`.
- `ss`  in  1  slave select, active low; asynchronous.
- `miso`  out  1  serial echo to master.
- `hours`  out  8  last committed hours.
- `minutes`  out  8  last committed minutes.
- `seconds`  out  8  last committed seconds.
- `time_valid`  out  1  one-clk pulse when a frame is committed.
- `frame_error`  out  1  one-clk pulse on range error or aborted frame.
- `busy`  out  1  high while a frame is in progress (state SHIFT).

## Operation
- Reset values:
  - `hours`, `minutes`, `seconds` = 0.
  - `time_valid`, `frame_error`, `busy` = 0.
  - `miso` = 0.
  - State = IDLE; counters cleared.
- Synchronize `scl`, `mosi`, `ss` through `SYNC_STAGES` flops, then detect edges (rise/fall strobes).
- States:
  - IDLE:
    - On `ss` fall: go to SHIFT.
    - Clear bit counter (0–7) and byte counter (0–2).
    - Load `miso` shift register with 8'h00.
  - SHIFT:
    - On `scl` fall: shift synchronized `mosi` into an 8-bit shift register, MSB first.
    - Increment the bit counter; on bit 8, store the byte in staging slot [byte counter] and increment the byte counter.
    - On `scl` rise: drive `miso` with the MSB of the echo register, then shift it left.
    - At each byte boundary, load the echo register with the byte just received, so byte n is echoed during byte n+1.
    - After the 24th bit, go to CHECK.
    - `ss` rise before the 24th bit: abort; pulse `frame_error`; discard staging; go to IDLE.
  - CHECK (one clk):
    - If hours < MAX_HOURS, minutes < MAX_MINSEC and seconds < MAX_MINSEC: load all three outputs simultaneously and pulse `time_valid`.
    - Otherwise pulse `frame_error`; outputs hold.
    - Go to DONE.
  - DONE:
    - Ignore further `scl` edges; `miso` = 0.
    - On `ss` rise: go to IDLE.
- Extra bits after bit 24 within the same `ss` window are ignored and are not an error.
- `ss` fall seen while not in IDLE is ignored. A new frame requires `ss` high then low.
- `reset` mid-frame: return to IDLE immediately and clear outputs; a partial frame is never committed.
- Range checks are unsigned 8-bit compares.

## Timing
- Input-to-strobe latency: `SYNC_STAGES` + 1 clk after a pin edge.
- `clk` must be ≥ 8× `scl` frequency. Each `scl` high/low phase must be ≥ `SYNC_STAGES` + 2 clk.
- Commit: outputs update and `time_valid` pulses 2 clk after the internal strobe of the 24th `scl` fall (one clk to shift, one clk in CHECK).
- `time_valid` and `frame_error` are never high in the same clk. Each is exactly 1 clk wide.
- Outputs are stable between commits; no partial update is ever visible.
- `busy` rises 1 clk after the internal `ss` fall strobe and falls on entry to CHECK or IDLE.

## Structure
- Shared package `spi_time_pkg`:
  - `BITS_PER_BYTE` = 8, `BYTES_PER_FRAME` = 3.
  - Default limits 24 and 60.
  - State enumeration IDLE/SHIFT/CHECK/DONE.
  - Byte-index constants HOURS_IDX = 0, MINUTES_IDX = 1, SECONDS_IDX = 2.
- Sub-module `sync_edge_det`:
  - Parameterized synchronizer plus rise/fall strobe generator.
  - Instantiated once each for `scl`, `mosi`, `ss` (`mosi` uses the level output only).

## Test plan
- Frame 8'h17, 8'h3B, 8'h3B at `clk`/10 `scl` → `hours`=23, `minutes`=59, `seconds`=59; one `time_valid` pulse; `frame_error` stays 0.
- Frame 8'h18, 8'h00, 8'h00 → `frame_error` pulse; outputs keep their previous values (0/0/0 after reset).
- `ss` raised after 12 bits of 8'h05, 8'h1E… → `frame_error` pulse; outputs unchanged; next full frame 8'h01, 8'h02, 8'h03 commits 1/2/3.
- Frame 8'h0A, 8'h14, 8'h1E → `miso` reads 8'h00, then 8'h0A, 8'h14 across the three bytes; commit 10/20/30.
- `reset` asserted mid-byte 2 of a valid frame → all outputs 0 at once; no `time_valid`; a subsequent frame is received correctly.
- Two back-to-back frames with `ss` high for 4 clk between them, and 30 extra `scl` cycles after bit 24 → two `time_valid` pulses; final values from the second frame.
